// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result/flags and MEM/WB control, traps on signed overflow.
// Latency 1 cycle; single entry, in_ready follows out_ready when full, blocks while a trap is pending.
// Optional macro EX_OVF_COUNT_EN adds a saturating ovf_count output.
module ex_mem_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_d,
    input  logic          alu_cout,
    input  logic          alu_v,
    input  logic [2:0]    alu_sel,
    input  logic          trap_ovf,
    input  logic [31:0]   in_pc,
    input  logic [RW-1:0] in_rd,
    input  logic          in_reg_write,
    input  logic          in_mem_read,
    input  logic          in_mem_write,
    input  logic [DW-1:0] in_store_data,
    input  logic          flush,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_result,
    output logic          out_zero,
    output logic          out_neg,
    output logic          out_cout,
    output logic          out_ovf,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write,
    output logic          out_mem_read,
    output logic          out_mem_write,
    output logic [DW-1:0] out_store_data,
    output logic          exc_valid,
    output logic [31:0]   exc_epc,
    input  logic          exc_ack
`ifdef EX_OVF_COUNT_EN
    ,
    output logic [15:0]   ovf_count
`endif
);

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_TRAP} state_t;

    state_t state, state_nxt;

    logic is_arith;
    logic accept;
    logic trap;
    logic load;
    logic reg_write_q, mem_read_q, mem_write_q;

    assign is_arith = (alu_sel == 3'b010) || (alu_sel == 3'b011);
    assign accept   = in_valid && in_ready && !flush;
    assign trap     = accept && is_arith && alu_v && trap_ovf;
    assign load     = accept && !trap;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // Next-state: flush beats accept, but a pending trap only leaves on exc_ack
    always_comb begin
        state_nxt = state;
        if (state == S_TRAP) begin
            if (exc_ack) state_nxt = S_EMPTY;
        end else if (flush) begin
            state_nxt = S_EMPTY;
        end else if (trap) begin
            state_nxt = S_TRAP;
        end else if (accept) begin
            state_nxt = S_FULL;
        end else if (state == S_FULL && out_ready) begin
            state_nxt = S_EMPTY;
        end
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        exc_valid = 1'b0;
        case (state)
            S_EMPTY: in_ready = 1'b1;
            S_FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            S_TRAP:  exc_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result     <= '0;
            out_zero       <= 1'b0;
            out_neg        <= 1'b0;
            out_cout       <= 1'b0;
            out_ovf        <= 1'b0;
            out_rd         <= '0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            out_store_data <= '0;
        end else if (load) begin
            out_result     <= alu_d;
            out_zero       <= (alu_d == '0);
            out_neg        <= alu_d[DW-1];
            out_cout       <= is_arith & alu_cout;
            out_ovf        <= is_arith & alu_v;
            out_rd         <= in_rd;
            reg_write_q    <= in_reg_write;
            mem_read_q     <= in_mem_read;
            mem_write_q    <= in_mem_write;
            out_store_data <= in_store_data;
        end
    end

    assign out_reg_write = reg_write_q & out_valid;
    assign out_mem_read  = mem_read_q  & out_valid;
    assign out_mem_write = mem_write_q & out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          exc_epc <= '0;
        else if (trap)                       exc_epc <= in_pc;
        else if (state == S_TRAP && exc_ack) exc_epc <= '0;
    end

`ifdef EX_OVF_COUNT_EN
    // Counts every accepted overflowing arithmetic op, trapping or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_count <= '0;
        else if (accept && is_arith && alu_v && ovf_count != 16'hFFFF)
            ovf_count <= ovf_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; define EX_OVF_COUNT_EN to also cover ovf_count.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_d;
    logic          alu_cout;
    logic          alu_v;
    logic [2:0]    alu_sel;
    logic          trap_ovf;
    logic [31:0]   in_pc;
    logic [RW-1:0] in_rd;
    logic          in_reg_write;
    logic          in_mem_read;
    logic          in_mem_write;
    logic [DW-1:0] in_store_data;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_result;
    logic          out_zero, out_neg, out_cout, out_ovf;
    logic [RW-1:0] out_rd;
    logic          out_reg_write, out_mem_read, out_mem_write;
    logic [DW-1:0] out_store_data;
    logic          exc_valid;
    logic [31:0]   exc_epc;
    logic          exc_ack;
`ifdef EX_OVF_COUNT_EN
    logic [15:0]   ovf_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_d(alu_d), .alu_cout(alu_cout), .alu_v(alu_v), .alu_sel(alu_sel),
        .trap_ovf(trap_ovf), .in_pc(in_pc), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_store_data(in_store_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_result(out_result), .out_zero(out_zero), .out_neg(out_neg),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_store_data(out_store_data),
        .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_ack(exc_ack)
`ifdef EX_OVF_COUNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] sel,
                         input logic c, input logic ov, input logic tr, input logic [31:0] pc);
        in_valid      = v;
        alu_d         = d;
        alu_sel       = sel;
        alu_cout      = c;
        alu_v         = ov;
        trap_ovf      = tr;
        in_pc         = pc;
        in_rd         = d[4:0];
        in_store_data = ~d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; exc_ack = 1'b0;
        in_reg_write = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b1;
        drive(1'b1, 32'h0000_0005, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", out_result); end
        total++; if (exc_valid !== 1'b0 || exc_epc !== 32'h0) begin bad++; $display("FAIL reset_exc got=%b/%h exp=0/0", exc_valid, exc_epc); end
        total++; if (out_reg_write !== 1'b0 || out_mem_write !== 1'b0) begin bad++; $display("FAIL reset_ctrl got=%b%b exp=00", out_reg_write, out_mem_write); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_result !== 32'h5) begin bad++; $display("FAIL first_accept got=%b/%h exp=1/5", out_valid, out_result); end
        total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL first_zero got=%b exp=0", out_zero); end
        total++; if (out_reg_write !== 1'b1 || out_mem_write !== 1'b1 || out_mem_read !== 1'b0) begin bad++; $display("FAIL first_ctrl got=%b%b%b exp=101", out_reg_write, out_mem_read, out_mem_write); end
        total++; if (out_rd !== 5'd5 || out_store_data !== 32'hFFFF_FFFA) begin bad++; $display("FAIL first_rd_sd got=%h/%h exp=05/fffffffa", out_rd, out_store_data); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin bad++; $display("FAIL drain got=%b/%b exp=0/0", out_valid, out_reg_write); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd100 + i, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
            step();
            total++; if (out_valid !== 1'b1 || out_result !== 32'd100 + i) begin bad++; $display("FAIL stream[%0d] got=%b/%0d exp=1/%0d", i, out_valid, out_result, 100 + i); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive(1'b1, 32'h11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h22, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
            step();
            total++; if (out_valid !== 1'b1 || out_result !== 32'h11) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/11", i, out_valid, out_result); end
        end
        // exc_ack while FULL must not disturb the entry
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'h11) begin bad++; $display("FAIL bp_ack_ignored got=%b/%h exp=1/11", out_valid, out_result); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_result !== 32'h22) begin bad++; $display("FAIL bp_next got=%b/%h exp=1/22", out_valid, out_result); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 3'b011, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        total++; if (out_zero !== 1'b1 || out_cout !== 1'b1 || out_neg !== 1'b0) begin bad++; $display("FAIL flags_zero got=z%b c%b n%b exp=z1 c1 n0", out_zero, out_cout, out_neg); end
        drive(1'b1, 32'h8000_0000, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0);
        step();
        total++; if (out_neg !== 1'b1 || out_cout !== 1'b0 || out_ovf !== 1'b0 || out_zero !== 1'b0) begin bad++; $display("FAIL flags_logic got=n%b c%b v%b z%b exp=n1 c0 v0 z0", out_neg, out_cout, out_ovf, out_zero); end
        total++; if (exc_valid !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL flags_no_trap got=%b/%b exp=0/1", exc_valid, out_valid); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_trap();
        out_ready = 1'b1;
        drive(1'b1, 32'h7FFF_FFF0, 3'b010, 1'b0, 1'b1, 1'b1, 32'h0040_0010);
        step();
        in_valid = 1'b0;
        #1;
        total++; if (exc_valid !== 1'b1 || exc_epc !== 32'h0040_0010) begin bad++; $display("FAIL trap_exc got=%b/%h exp=1/00400010", exc_valid, exc_epc); end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_reg_write !== 1'b0) begin bad++; $display("FAIL trap_block got=%b/%b/%b exp=0/0/0", out_valid, in_ready, out_reg_write); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (exc_valid !== 1'b1 || exc_epc !== 32'h0040_0010) begin bad++; $display("FAIL trap_flush_ignored got=%b/%h exp=1/00400010", exc_valid, exc_epc); end
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        total++; if (exc_valid !== 1'b0 || exc_epc !== 32'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL trap_ack got=%b/%h/%b/%b exp=0/0/1/0", exc_valid, exc_epc, in_ready, out_valid); end
        drive(1'b1, 32'h7FFF_FFF0, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0040_0010);
        step();
        total++; if (out_valid !== 1'b1 || out_ovf !== 1'b1 || exc_valid !== 1'b0 || out_result !== 32'h7FFF_FFF0) begin bad++; $display("FAIL notrap_fwd got=%b/%b/%b/%h exp=1/1/0/7ffffff0", out_valid, out_ovf, exc_valid, out_result); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive(1'b1, 32'h33, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        total++; if (out_valid !== 1'b1 || out_reg_write !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b/%b exp=1/1", out_valid, out_reg_write); end
        flush = 1'b1;
        drive(1'b1, 32'h44, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_mem_write !== 1'b0) begin bad++; $display("FAIL flush_kill got=%b/%b/%b exp=0/0/0", out_valid, out_reg_write, out_mem_write); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 3'b011, 1'b1, 1'b1, 1'b1, 32'h0000_0ABC);
        step();
        in_valid = 1'b0;
        #2;
        total++; if (exc_valid !== 1'b1 || exc_epc !== 32'h0000_0ABC) begin bad++; $display("FAIL ar_trap got=%b/%h exp=1/00000abc", exc_valid, exc_epc); end
        rst_n = 1'b0;
        #1;
        total++; if (exc_valid !== 1'b0 || exc_epc !== 32'h0 || in_ready !== 1'b1 || out_result !== 32'h0) begin bad++; $display("FAIL ar_clear got=%b/%h/%b/%h exp=0/0/1/0", exc_valid, exc_epc, in_ready, out_result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef EX_OVF_COUNT_EN
    task automatic test_ovf_count();
        out_ready = 1'b1;
        total++; if (ovf_count !== 16'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", ovf_count); end
        drive(1'b1, 32'h1, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h2, 3'b011, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        // overflow flag on a non-arithmetic op is not counted
        drive(1'b1, 32'h3, 3'b001, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h4, 3'b010, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        step();
        in_valid = 1'b0;
        total++; if (ovf_count !== 16'd3) begin bad++; $display("FAIL cnt_three got=%0d exp=3", ovf_count); end
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flags();
        test_trap();
        test_flush();
        test_async_reset();
`ifdef EX_OVF_COUNT_EN
        test_ovf_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
